// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types for the RAM bus arbiter: FSM states, request sources and lane helpers.
package ram_bus_arbiter_pkg;

    typedef enum logic {
        StIdle,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        SrcHost,
        SrcIbus,
        SrcDbus
    } src_e;

    function automatic int unsigned lane_count(int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req/gnt bit 0 is ibus, bit 1 is dbus.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0: ibus was granted last, 1: dbus was granted last
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (gnt[1]) begin
            last_q <= 1'b1;
        end else if (gnt[0]) begin
            last_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Single-port RAM arbiter between a byte-serial host port and the SERV ibus/dbus.
// Each access is granted in IDLE and acknowledged one cycle later in RESP.
module ram_bus_arbiter
    import ram_bus_arbiter_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       host_valid,
    input  logic                       host_we,
    input  logic [AW+$clog2(DW/8)-1:0] host_addr,
    input  logic [7:0]                 host_wdata,
    output logic [7:0]                 host_rdata,
    output logic                       host_done,
    output logic                       host_busy,
    input  logic                       ibus_cyc,
    input  logic [31:0]                ibus_adr,
    output logic [DW-1:0]              ibus_rdt,
    output logic                       ibus_ack,
    input  logic                       dbus_cyc,
    input  logic                       dbus_we,
    input  logic [31:0]                dbus_adr,
    input  logic [DW-1:0]              dbus_dat,
    input  logic [DW/8-1:0]            dbus_sel,
    output logic [DW-1:0]              dbus_rdt,
    output logic                       dbus_ack,
    output logic                       ram_en,
    output logic [AW-1:0]              ram_addr,
    output logic [DW/8-1:0]            ram_we,
    output logic [DW-1:0]              ram_din,
    input  logic [DW-1:0]              ram_dout,
    output logic                       err_unmapped
);

    localparam int unsigned NB  = lane_count(DW);
    localparam int unsigned LB  = $clog2(NB);
    localparam int unsigned LW  = (LB > 0) ? LB : 1;
    localparam int unsigned HAW = AW + LB;

    state_e         state_q;
    src_e           src_q;
    logic           mapped_q;
    logic           host_pend_q;
    logic           host_we_q;
    logic [HAW-1:0] host_addr_q;
    logic [7:0]     host_wdata_q;
    logic [7:0]     host_rdata_q;

    logic [LW-1:0]  host_lane;
    logic [AW-1:0]  host_waddr;
    logic [AW-1:0]  ibus_waddr;
    logic [AW-1:0]  dbus_waddr;
    logic [NB-1:0]  host_mask;
    logic [7:0]     rd_byte;
    logic [DW-1:0]  resp_data;

    logic           idle;
    logic           gnt_host;
    logic           gnt_ibus;
    logic           gnt_dbus;
    logic           gnt_any;
    logic           gnt_mapped;
    src_e           gnt_src;
    logic [AW-1:0]  gnt_addr;
    logic [NB-1:0]  gnt_we;
    logic [DW-1:0]  gnt_din;
    logic [1:0]     rr_gnt;
    logic           unused_adr;

    function automatic logic is_mapped(logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    assign host_lane  = (LB > 0) ? host_addr_q[LW-1:0] : '0;
    assign host_waddr = host_addr_q[HAW-1:LB];
    assign ibus_waddr = ibus_adr[AW+1:2];
    assign dbus_waddr = dbus_adr[AW+1:2];
    assign unused_adr = ^{ibus_adr[31:AW+2], ibus_adr[1:0], dbus_adr[31:AW+2], dbus_adr[1:0]};

    // Grants only happen in IDLE; a pending host request blocks the bus arbiter.
    assign idle     = (state_q == StIdle) && !rst;
    assign gnt_host = idle && host_pend_q;

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .en  (idle && !host_pend_q),
        .req ({dbus_cyc, ibus_cyc}),
        .gnt (rr_gnt)
    );

    assign gnt_ibus = rr_gnt[0];
    assign gnt_dbus = rr_gnt[1];
    assign gnt_any  = gnt_host || gnt_ibus || gnt_dbus;

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            host_mask[b] = (host_lane == LW'(b));
        end
    end

    always_comb begin
        gnt_src  = SrcIbus;
        gnt_addr = '0;
        gnt_we   = '0;
        gnt_din  = '0;
        if (gnt_host) begin
            gnt_src  = SrcHost;
            gnt_addr = host_waddr;
            gnt_we   = host_we_q ? host_mask : '0;
            gnt_din  = {NB{host_wdata_q}};
        end else if (gnt_dbus) begin
            gnt_src  = SrcDbus;
            gnt_addr = dbus_waddr;
            gnt_we   = dbus_we ? dbus_sel : '0;
            gnt_din  = dbus_dat;
        end else if (gnt_ibus) begin
            gnt_src  = SrcIbus;
            gnt_addr = ibus_waddr;
        end
    end

    assign gnt_mapped = is_mapped(gnt_addr);
    assign ram_en     = gnt_any && gnt_mapped;
    assign ram_addr   = ram_en ? gnt_addr : '0;
    assign ram_we     = ram_en ? gnt_we : '0;
    assign ram_din    = ram_en ? gnt_din : '0;

    // Unmapped accesses never enabled the RAM, so their read data is forced to zero.
    assign resp_data = mapped_q ? ram_dout : '0;
    assign ibus_rdt  = ibus_ack ? resp_data : '0;
    assign dbus_rdt  = dbus_ack ? resp_data : '0;

    always_comb begin
        rd_byte = '0;
        for (int b = 0; b < NB; b++) begin
            if (host_lane == LW'(b)) begin
                rd_byte = resp_data[8*b +: 8];
            end
        end
    end

    assign host_rdata = (host_done && !host_we_q) ? rd_byte : host_rdata_q;
    assign host_busy  = host_pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            src_q        <= SrcIbus;
            mapped_q     <= 1'b0;
            host_pend_q  <= 1'b0;
            host_we_q    <= 1'b0;
            host_addr_q  <= '0;
            host_wdata_q <= '0;
            host_rdata_q <= '0;
            ibus_ack     <= 1'b0;
            dbus_ack     <= 1'b0;
            host_done    <= 1'b0;
            err_unmapped <= 1'b0;
        end else begin
            if (host_valid && !host_pend_q) begin
                host_pend_q  <= 1'b1;
                host_we_q    <= host_we;
                host_addr_q  <= host_addr;
                host_wdata_q <= host_wdata;
            end
            ibus_ack  <= 1'b0;
            dbus_ack  <= 1'b0;
            host_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_any) begin
                        state_q   <= StResp;
                        src_q     <= gnt_src;
                        mapped_q  <= gnt_mapped;
                        ibus_ack  <= gnt_ibus;
                        dbus_ack  <= gnt_dbus;
                        host_done <= gnt_host;
                        if (!gnt_mapped) begin
                            err_unmapped <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    if (src_q == SrcHost) begin
                        host_pend_q <= 1'b0;
                        if (!host_we_q) begin
                            host_rdata_q <= rd_byte;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

- Parametrised single-port RAM arbiter between a byte-serial host load port and the SERV instruction and data Wishbone buses.
- Sits between the CPU, the pin-level host interface and one RAM macro, replacing direct combinational ack/data wiring.
- Provides registered 1-wait-state acks, byte-lane writes of configurable word width, fair ibus/dbus arbitration and out-of-range address handling.

## Interface
Parameters:
- DW, 32, RAM word width in bits; multiple of 8, 8..64
- AW, 5, RAM word-address width
- DEPTH, 32, implemented words; 1..2^AW; addresses at or above DEPTH are unmapped

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- host_valid  in  1  one-cycle host request pulse
- host_we  in  1  1 = write byte, 0 = read byte
- host_addr  in  AW+log2(DW/8)  host byte address
- host_wdata  in  8  host write byte
- host_rdata  out  8  registered read byte; holds until the next host read completes
- host_done  out  1  one-cycle pulse when the host access completes
- host_busy  out  1  a host request is pending or in service
- ibus_cyc / ibus_adr[31:0]  in  instruction fetch request; word address = adr[AW+1:2]
- ibus_rdt  out  DW  fetch data, valid only while ibus_ack is high
- ibus_ack  out  1  one-cycle fetch acknowledge
- dbus_cyc, dbus_we  in  1  data request and write strobe
- dbus_adr  in  32  data byte address
- dbus_dat  in  DW  data write word
- dbus_sel  in  DW/8  data byte-lane selects
- dbus_rdt  out  DW  data read word, valid only while dbus_ack is high
- dbus_ack  out  1  one-cycle data acknowledge
- ram_en  out  1  RAM enable
- ram_addr  out  AW  RAM word address
- ram_we  out  DW/8  RAM per-lane write enables
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data; valid one cycle after ram_en
- err_unmapped  out  1  sticky flag: an unmapped address was accessed; cleared only by rst

## Operation
State machine with two states: IDLE and RESP.

- **Host latch:** host_valid sets a pending flag and captures we, addr and wdata. host_valid while host_busy=1 is ignored.
- **IDLE:** grant one requester in priority order:
  - pending host first;
  - then ibus/dbus round-robin. When both request, grant the one not granted last; the last-grant bit resets to ibus, so dbus wins the first tie.
- **Drive on grant:** the winner drives the RAM combinationally in the same cycle, then the FSM moves to RESP with the granted source latched.
  - Host write: ram_we has one lane set, lane = host_addr[log2(DW/8)-1:0]; ram_din = host_wdata replicated across all lanes.
  - dbus write: ram_we = dbus_sel; ram_din = dbus_dat.
  - All reads: ram_we = 0.
- **RESP:** pulse the granted source's ack or done, then return to IDLE.
  - rdt = ram_dout.
  - For a host read, host_rdata takes the lane byte of ram_dout selected by the latched lane.
- **Unmapped address (word address ≥ DEPTH):**
  - ram_en is held 0 for that access;
  - the access is still acked in RESP with rdt = 0 (host_rdata = 0);
  - err_unmapped is set.
- **Masters:** must follow Wishbone-classic behaviour and drop cyc in the cycle after ack. cyc still high in IDLE is a new request.
- **Reset values (rst=1):** FSM = IDLE; pending flag, all acks, host_done, host_busy, ram_en, ram_we, err_unmapped = 0; host_rdata = 0; last-grant bit = ibus.
- **Reset mid-access:** the access is abandoned with no ack; the RAM state for that access is undefined.

## Timing
- Every access takes 2 cycles: grant in cycle N, ack or done in cycle N+1.
- Earliest next grant is N+2, so peak throughput is one access per 2 cycles.
- A host request arriving in cycle N (host_valid) is granted at the earliest in N+1, if the FSM is in IDLE.
- Back-to-back bus requests alternate: the worst-case wait for ibus or dbus is 4 cycles, plus 2 more if a host request intervenes.
- Outputs:
  - ack, rdt, host_done and host_rdata are registered or state-decoded; none depends combinationally on cyc.
  - ram_* outputs are combinational from the request inputs in IDLE.
  - ram_* outputs are all 0 in RESP.

## Structure
- Shared package: state encoding (IDLE, RESP); source encoding (SRC_HOST, SRC_IBUS, SRC_DBUS); lane-count function DW/8.
- One natural sub-module: `rr_arb2`, the 2-way round-robin arbiter with its last-grant register.
- Everything else stays flat in ram_bus_arbiter.

## Test plan
- **Host write then read:** host write of 0xA5 to byte address 6 (DW=32), then host read of address 6.
  - Write cycle: ram_we = 4'b0100, ram_addr = 1.
  - Read: host_rdata = 0xA5 with host_done one cycle after grant.
- **dbus write then ibus fetch:** dbus write of 0xDEADBEEF with sel = 4'b1111 to address 0x8, then an ibus fetch from 0x8.
  - ibus_ack pulses for exactly one cycle with ibus_rdt = 0xDEADBEEF.
- **Simultaneous requests:** ibus_cyc and dbus_cyc held high together for 8 cycles.
  - Grant order is dbus, ibus, dbus, ibus.
  - Acks appear in cycles 2, 4, 6 and 8; never two acks in the same cycle.
- **Host priority and ignored pulse:** host_valid in the same cycle as a pending dbus request.
  - Host is served first.
  - A second host_valid while host_busy=1 produces no extra host_done.
- **Unmapped address:** DEPTH = 24, dbus read of word 28 (byte address 0x70).
  - ram_en = 0; dbus_ack is still asserted with dbus_rdt = 0; err_unmapped = 1 and stays 1.
- **Reset during RESP:** assert rst in the RESP cycle.
  - No ack is issued; all outputs read 0; the FSM is in IDLE.
  - The next ibus request completes normally.
